// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for the multicycle RISC-V core.
// Issues word reads to instruction memory (combinational return), buffers the
// fetched words in a QDEPTH-entry queue and presents them to decode.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   en                   run enable
//   mem_addr/mem_re      word index / read enable to instruction memory
//   mem_out              instruction word returned in the same cycle
//   redirect/redirect_pc taken branch and its new byte PC
//   instr/instr_pc       head-of-queue word and its byte PC
//   instr_valid          queue not empty
//   instr_ready          decode accepts head this cycle
//   fault                sticky misaligned-redirect / out-of-range fault
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fault
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FAULT} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_hold_instr;
  logic [31:0]   r_hold_pc;
  logic          r_fault;

  logic [31:0]   w_word_pc;
  logic          w_valid;
  logic          w_room;
  logic          w_oor;
  logic          w_try;
  logic          w_issue;
  logic          w_pop;
  logic          w_flush;
  logic          w_misalign;

  assign w_word_pc  = {2'b00, r_fetch_pc[31:2]};
  assign w_valid    = (r_count != '0);
  // A full queue still has room when the head leaves this cycle.
  assign w_room     = (r_count < CW'(QDEPTH)) || instr_ready;
  assign w_oor      = (w_word_pc >= 32'(MEM_WORDS));
  // An issue would occur this cycle, before the range check.
  assign w_try      = (r_state == S_FETCH) && en && !redirect && w_room;
  assign w_misalign = (redirect_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (en) w_next_state = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          if (w_misalign) w_next_state = S_FAULT;
        end else if (w_try && w_oor) begin
          w_next_state = S_FAULT;
        end
      end
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-state queue/memory controls; redirect outranks push and pop
  always_comb begin
    w_issue = 1'b0;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_flush = redirect;
        w_pop   = w_valid && instr_ready && !redirect;
        w_issue = w_try && !w_oor;
      end
      S_FAULT: w_pop = w_valid && instr_ready;
      default: ;
    endcase
  end

  assign mem_re      = w_issue;
  assign mem_addr    = w_issue ? w_word_pc : r_mem_addr;
  assign instr_valid = w_valid;
  assign instr       = w_valid ? r_q_instr[r_rd_ptr] : r_hold_instr;
  assign instr_pc    = w_valid ? r_q_pc[r_rd_ptr]    : r_hold_pc;
  assign fault       = r_fault;

  // Fetch PC, queue storage and held outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_mem_addr   <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_fault      <= 1'b0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_fault <= (w_next_state == S_FAULT);
      // Remember what was last shown so an empty queue keeps it on the outputs.
      if (w_valid) begin
        r_hold_instr <= r_q_instr[r_rd_ptr];
        r_hold_pc    <= r_q_pc[r_rd_ptr];
      end
      if (w_flush) begin
        r_fetch_pc <= redirect_pc;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) begin
          r_q_instr[r_wr_ptr] <= mem_out;
          r_q_pc[r_wr_ptr]    <= r_fetch_pc;
          r_wr_ptr            <= PW'(r_wr_ptr + PW'(1));
          r_fetch_pc          <= r_fetch_pc + 32'd4;
          r_mem_addr          <= w_word_pc;
        end
        if (w_pop) r_rd_ptr <= PW'(r_rd_ptr + PW'(1));
        r_count <= CW'(r_count + CW'(w_issue) - CW'(w_pop));
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory plus a
// queue of expected byte PCs, popped and checked on every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;

  logic [31:0] mem [256];
  logic [31:0] expq [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign mem_out = (mem_re === 1'b1 && mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(256), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_out(mem_out),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fault(fault)
  );

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    n_vec++;
    if (mem_re !== 1'b0 || mem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        instr_valid !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: re=%b addr=%h instr=%h pc=%h valid=%b fault=%b, all zero required",
               mem_re, mem_addr, instr, instr_pc, instr_valid, fault);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] e;
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      expq.push_back(32'(4 * c));
      n_vec++;
      if (mem_re !== 1'b1 || mem_addr !== 32'(c)) begin
        n_err++; $display("FAIL seq_issue: re=%b addr=%h, required 1/%h", mem_re, mem_addr, 32'(c));
      end
      n_vec++;
      if (instr_valid !== 1'(c >= 1)) begin
        n_err++; $display("FAIL seq_valid: cycle %0d valid=%b required %b", c, instr_valid, c >= 1);
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL seq_pop: unexpected pc %h", instr_pc);
        end else begin
          e = expq.pop_front();
          if (instr_pc !== e || instr !== mem[e[9:2]]) begin
            n_err++; $display("FAIL seq_pop: got %h/%h required %h/%h", instr_pc, instr, e, mem[e[9:2]]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    int delivered = 0;
    int issued = 0;
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      instr_ready = !(c >= 1 && c <= 5);
      #1;
      if (c <= 1 || c >= 6) begin
        expq.push_back(32'(4 * issued)); issued++;
      end
      if (c >= 2 && c <= 5) begin
        n_vec++;
        if (mem_re !== 1'b0 || mem_addr !== 32'd1 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
          n_err++;
          $display("FAIL bp_stall: re=%b addr=%h valid=%b pc=%h, required 0/1/1/0", mem_re, mem_addr, instr_valid, instr_pc);
        end
      end
      if (c >= 6) begin
        n_vec++;
        if (mem_re !== 1'b1 || mem_addr !== 32'(c - 4)) begin
          n_err++; $display("FAIL bp_resume: re=%b addr=%h required 1/%h", mem_re, mem_addr, 32'(c - 4));
        end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        n_vec++; delivered++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL bp_pop: unexpected pc %h", instr_pc);
        end else begin
          e = expq.pop_front();
          if (instr_pc !== e || instr !== mem[e[9:2]]) begin
            n_err++; $display("FAIL bp_pop: got %h/%h required %h/%h", instr_pc, instr, e, mem[e[9:2]]);
          end
        end
      end
    end
    n_vec++;
    if (delivered != 9) begin
      n_err++; $display("FAIL bp_count: delivered %0d required 9", delivered);
    end
  endtask

  task automatic test_redirect;
    logic [31:0] e;
    do_reset();
    en = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2C;
    #1;
    n_vec++;
    if (mem_re !== 1'b0 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL redir_cycle: re=%b valid=%b required 0/1", mem_re, instr_valid);
    end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_vec++;
    if (instr_valid !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'd11) begin
      n_err++; $display("FAIL redir_flush: valid=%b re=%b addr=%h required 0/1/b", instr_valid, mem_re, mem_addr);
    end
    for (int c = 0; c < 6; c++) expq.push_back(32'h2C + 32'(4 * c));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (instr_valid !== 1'b1 || expq.size() == 0) begin
        n_err++; $display("FAIL redir_stream: cycle %0d valid=%b required 1", c, instr_valid);
      end else begin
        e = expq.pop_front();
        if (instr_pc !== e || instr !== mem[e[9:2]]) begin
          n_err++; $display("FAIL redir_stream: got %h/%h required %h/%h", instr_pc, instr, e, mem[e[9:2]]);
        end
      end
    end
  endtask

  task automatic test_misaligned;
    do_reset();
    en = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h06;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_vec++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || mem_re !== 1'b0) begin
      n_err++; $display("FAIL misalign: fault=%b valid=%b re=%b required 1/0/0", fault, instr_valid, mem_re);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      en = c[0]; instr_ready = 1'b1;
      redirect = (c == 3); redirect_pc = 32'h10;
      #1;
      n_vec++;
      if (fault !== 1'b1 || instr_valid !== 1'b0 || mem_re !== 1'b0) begin
        n_err++; $display("FAIL misalign_sticky: cycle %0d fault=%b valid=%b re=%b required 1/0/0", c, fault, instr_valid, mem_re);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [31:0] e;
    logic [31:0] last_pc = 32'hFFFF_FFFF;
    int delivered = 0;
    bit done = 1'b0;
    do_reset();
    for (int c = 0; c < 256; c++) expq.push_back(32'(4 * c));
    en = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (mem_re === 1'b1 && mem_addr >= 32'd256) begin
        n_err++; $display("FAIL oor_issue: re=1 addr=%h, required addr<100", mem_addr);
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        n_vec++; delivered++; last_pc = instr_pc;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL oor_pop: unexpected pc %h", instr_pc);
        end else begin
          e = expq.pop_front();
          if (instr_pc !== e || instr !== mem[e[9:2]]) begin
            n_err++; $display("FAIL oor_pop: got %h/%h required %h/%h", instr_pc, instr, e, mem[e[9:2]]);
          end
        end
      end
      if (fault === 1'b1 && instr_valid === 1'b0) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL oor_timeout: fault=%b valid=%b after 400 cycles, required 1/0", fault, instr_valid);
    end
    n_vec++;
    if (delivered != 256 || last_pc !== 32'h3FC || fault !== 1'b1) begin
      n_err++; $display("FAIL oor_end: delivered=%0d last_pc=%h fault=%b required 256/3fc/1", delivered, last_pc, fault);
    end
  endtask

  task automatic test_midrun_reset;
    logic [31:0] e;
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_re !== 1'b0 || mem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        instr_valid !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: re=%b addr=%h instr=%h pc=%h valid=%b fault=%b, all zero required",
               mem_re, mem_addr, instr, instr_pc, instr_valid, fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    for (int c = 0; c < 5; c++) expq.push_back(32'(4 * c));
    @(negedge clk); #1;
    n_vec++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_first: re=%b addr=%h valid=%b required 1/0/0", mem_re, mem_addr, instr_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (instr_valid !== 1'b1 || expq.size() == 0) begin
        n_err++; $display("FAIL midrst_stream: cycle %0d valid=%b required 1", c, instr_valid);
      end else begin
        e = expq.pop_front();
        if (instr_pc !== e || instr !== mem[e[9:2]]) begin
          n_err++; $display("FAIL midrst_stream: got %h/%h required %h/%h", instr_pc, instr, e, mem[e[9:2]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h0030_2183;
    mem[1] = 32'h0070_2203;
    rst_n = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_out_of_range();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
